// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared definitions for the next-PC sequencer:
//   - state_e      : sequencer states (BOOT / RUN / HOLD / TRAP)
//   - SEL_*        : encodings of the 5-way next-PC mux select
//   - rank_t/RANK_*: priority rank of a redirect request, higher wins,
//                    RANK_NONE means "no redirect, fall through to pc+4"
//   - INSN_BYTES   : sequential fetch increment
//   - rankToSel    : maps a redirect rank to the mux select it produces
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    TRAP = 2'd3
  } state_e;

  localparam logic [2:0] SEL_PC4  = 3'd0;
  localparam logic [2:0] SEL_JALR = 3'd1;
  localparam logic [2:0] SEL_BR   = 3'd2;
  localparam logic [2:0] SEL_JMP  = 3'd3;
  localparam logic [2:0] SEL_EXC  = 3'd4;

  localparam logic [31:0] INSN_BYTES = 32'd4;

  typedef logic [2:0] rank_t;

  localparam rank_t RANK_NONE = 3'd0;
  localparam rank_t RANK_JMP  = 3'd1;
  localparam rank_t RANK_BR   = 3'd2;
  localparam rank_t RANK_JALR = 3'd3;
  localparam rank_t RANK_ERET = 3'd4;

  // eret returns along the sequential path, so it reports the pc+4 select
  function automatic logic [2:0] rankToSel(input rank_t r);
    logic [2:0] s;
    case (r)
      RANK_JALR: s = SEL_JALR;
      RANK_BR:   s = SEL_BR;
      RANK_JMP:  s = SEL_JMP;
      default:   s = SEL_PC4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pc_redirect_pri.sv
// pc_redirect_pri
// Combinational priority encoder for redirect requests.
// Ports:
//   i_eretTake/i_eretTgt  return-from-exception request (highest redirect rank)
//   i_jalrTake/i_jalrTgt  jalr request
//   i_brTake/i_brTgt      taken branch
//   i_jmpTake/i_jmpTgt    jump request (lowest redirect rank)
//   i_pendRank/i_pendTgt  request buffered while stalled (RANK_NONE if empty)
//   o_liveRank/o_liveTgt  best request among this cycle's inputs only
//   o_rank/o_sel/o_tgt    overall winner including the pending slot
//   o_misalign            overall winner's target is not word aligned
module pc_redirect_pri
  import pc_seq_pkg::*;
(
  input  logic        i_eretTake,
  input  logic [31:0] i_eretTgt,
  input  logic        i_jalrTake,
  input  logic [31:0] i_jalrTgt,
  input  logic        i_brTake,
  input  logic [31:0] i_brTgt,
  input  logic        i_jmpTake,
  input  logic [31:0] i_jmpTgt,
  input  rank_t       i_pendRank,
  input  logic [31:0] i_pendTgt,
  output rank_t       o_liveRank,
  output logic [31:0] o_liveTgt,
  output rank_t       o_rank,
  output logic [2:0]  o_sel,
  output logic [31:0] o_tgt,
  output logic        o_misalign
);

  // Fixed-priority pick among the requests arriving this cycle
  always_comb begin
    o_liveRank = RANK_NONE;
    o_liveTgt  = '0;
    if (i_eretTake) begin
      o_liveRank = RANK_ERET;
      o_liveTgt  = i_eretTgt;
    end else if (i_jalrTake) begin
      o_liveRank = RANK_JALR;
      o_liveTgt  = i_jalrTgt;
    end else if (i_brTake) begin
      o_liveRank = RANK_BR;
      o_liveTgt  = i_brTgt;
    end else if (i_jmpTake) begin
      o_liveRank = RANK_JMP;
      o_liveTgt  = i_jmpTgt;
    end
  end

  // The buffered request is older, so it keeps ties against live inputs
  always_comb begin
    if ((i_pendRank != RANK_NONE) && (i_pendRank >= o_liveRank)) begin
      o_rank = i_pendRank;
      o_tgt  = i_pendTgt;
    end else begin
      o_rank = o_liveRank;
      o_tgt  = o_liveTgt;
    end
    o_sel      = rankToSel(o_rank);
    o_misalign = (o_rank != RANK_NONE) && (o_tgt[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC controller: owns the fetch PC, picks the next-PC source
// (pc+4, jalr, branch, jump, exception), buffers redirects seen while
// stalled and sequences exception entry through a one-cycle TRAP state.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   stall                 hold the PC
//   jalr/br/jmp _take/_tgt redirect requests and targets
//   exc_req               exception request (beats everything, even stall)
//   eret                  return from exception
//   pc, sel               registered fetch PC and the select that produced it
//   fetch_vld             pc is a valid fetch address
//   redirect/exc_ack/misalign  one-cycle pulses
//   epc                   saved exception PC
// Configuration macro PC_SEQ_EPC_EN: when defined, exception entry saves the
// faulting PC into epc and eret returns to epc+4; otherwise epc reads zero
// and eret is ignored.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h00001000,
  parameter logic [31:0] EXC_VEC   = 32'h00000080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jalr_take,
  input  logic [31:0] jalr_tgt,
  input  logic        br_take,
  input  logic [31:0] br_tgt,
  input  logic        jmp_take,
  input  logic [31:0] jmp_tgt,
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [2:0]  sel,
  output logic        fetch_vld,
  output logic        redirect,
  output logic        exc_ack,
  output logic        misalign,
  output logic [31:0] epc
);

  state_e      r_state, w_stateNext;
  logic [31:0] r_pc, w_pcNext;
  logic [2:0]  r_sel, w_selNext;
  logic        r_redirect, w_redirectNext;
  logic        r_excAck, w_excAckNext;
  logic        r_misalign, w_misalignNext;
  rank_t       r_pendRank, w_pendRankNext;
  logic [31:0] r_pendTgt, w_pendTgtNext;

  logic        w_eretTake;
  logic [31:0] w_eretTgt;
  rank_t       w_liveRank, w_rank;
  logic [31:0] w_liveTgt, w_tgt;
  logic [2:0]  w_sel;
  logic        w_misalign;
  logic        w_active;
  logic        w_takeExc;
  logic        w_excEntry;

`ifdef PC_SEQ_EPC_EN
  logic [31:0] r_epc;

  assign w_eretTake = eret;
  assign w_eretTgt  = r_epc + INSN_BYTES;
  assign epc        = r_epc;

  // The faulting fetch address is captured on every exception entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_epc <= '0;
    end else if (w_excEntry) begin
      r_epc <= r_pc;
    end
  end
`else
  logic w_unusedEret;

  assign w_eretTake   = 1'b0;
  assign w_eretTgt    = '0;
  assign epc          = '0;
  assign w_unusedEret = eret;
`endif

  pc_redirect_pri u_pri (
    .i_eretTake (w_eretTake),
    .i_eretTgt  (w_eretTgt),
    .i_jalrTake (jalr_take),
    .i_jalrTgt  (jalr_tgt),
    .i_brTake   (br_take),
    .i_brTgt    (br_tgt),
    .i_jmpTake  (jmp_take),
    .i_jmpTgt   (jmp_tgt),
    .i_pendRank (r_pendRank),
    .i_pendTgt  (r_pendTgt),
    .o_liveRank (w_liveRank),
    .o_liveTgt  (w_liveTgt),
    .o_rank     (w_rank),
    .o_sel      (w_sel),
    .o_tgt      (w_tgt),
    .o_misalign (w_misalign)
  );

  // A misaligned target only matters when it is actually about to be taken
  assign w_active   = (r_state == RUN) || (r_state == HOLD);
  assign w_takeExc  = exc_req || (!stall && w_misalign);
  assign w_excEntry = w_active && w_takeExc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      BOOT: w_stateNext = RUN;
      TRAP: w_stateNext = RUN;
      RUN, HOLD: begin
        if (w_takeExc) begin
          w_stateNext = TRAP;
        end else if (stall) begin
          w_stateNext = HOLD;
        end else begin
          w_stateNext = RUN;
        end
      end
      default: w_stateNext = BOOT;
    endcase
  end

  // Output logic: fetch valid plus the next values of the PC datapath
  always_comb begin
    fetch_vld      = w_active;
    w_pcNext       = r_pc;
    w_selNext      = r_sel;
    w_redirectNext = 1'b0;
    w_excAckNext   = 1'b0;
    w_misalignNext = 1'b0;
    w_pendRankNext = r_pendRank;
    w_pendTgtNext  = r_pendTgt;
    case (r_state)
      TRAP: begin
        w_pcNext       = r_pc + INSN_BYTES;
        w_selNext      = SEL_PC4;
        w_pendRankNext = RANK_NONE;
      end
      RUN, HOLD: begin
        if (w_takeExc) begin
          w_pcNext       = EXC_VEC;
          w_selNext      = SEL_EXC;
          w_redirectNext = 1'b1;
          w_excAckNext   = 1'b1;
          w_misalignNext = !exc_req;
          w_pendRankNext = RANK_NONE;
        end else if (stall) begin
          if (w_liveRank > r_pendRank) begin
            w_pendRankNext = w_liveRank;
            w_pendTgtNext  = w_liveTgt;
          end
        end else begin
          w_pendRankNext = RANK_NONE;
          if (w_rank == RANK_NONE) begin
            w_pcNext  = r_pc + INSN_BYTES;
            w_selNext = SEL_PC4;
          end else begin
            w_pcNext       = w_tgt;
            w_selNext      = w_sel;
            w_redirectNext = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // PC datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_VEC;
      r_sel      <= SEL_PC4;
      r_redirect <= 1'b0;
      r_excAck   <= 1'b0;
      r_misalign <= 1'b0;
      r_pendRank <= RANK_NONE;
      r_pendTgt  <= '0;
    end else begin
      r_pc       <= w_pcNext;
      r_sel      <= w_selNext;
      r_redirect <= w_redirectNext;
      r_excAck   <= w_excAckNext;
      r_misalign <= w_misalignNext;
      r_pendRank <= w_pendRankNext;
      r_pendTgt  <= w_pendTgtNext;
    end
  end

  assign pc       = r_pc;
  assign sel      = r_sel;
  assign redirect = r_redirect;
  assign exc_ack  = r_excAck;
  assign misalign = r_misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Drives pc_sequencer with directed sequences followed by random traffic and
// compares every cycle against a behavioural model of the fetch PC rules.
// Honours PC_SEQ_EPC_EN the same way the design does.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h00001000;
  localparam logic [31:0] EXC_VEC   = 32'h00000080;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jalr_take, br_take, jmp_take, exc_req, eret;
  logic [31:0] jalr_tgt, br_tgt, jmp_tgt;
  logic [31:0] pc, epc;
  logic [2:0]  sel;
  logic        fetch_vld, redirect, exc_ack, misalign;

  int nChecks = 0;
  int nFails  = 0;
  bit cmpEn   = 1'b0;

  // Model state: expected outputs plus the few facts the rules depend on
  logic [31:0] ePc, eEpc, mPendTgt;
  logic [2:0]  eSel;
  logic        eFv, eRed, eAck, eMis;
  int          mPendRank;
  bit          mBoot, mTrap;
  int          mBestRank;
  logic [31:0] mBestTgt;
  bit          mTk[4];
  logic [31:0] mTg[4];
  logic [31:0] rT0, rT1, rT2;

  pc_sequencer #(.RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jalr_take (jalr_take),
    .jalr_tgt  (jalr_tgt),
    .br_take   (br_take),
    .br_tgt    (br_tgt),
    .jmp_take  (jmp_take),
    .jmp_tgt   (jmp_tgt),
    .exc_req   (exc_req),
    .eret      (eret),
    .pc        (pc),
    .sel       (sel),
    .fetch_vld (fetch_vld),
    .redirect  (redirect),
    .exc_ack   (exc_ack),
    .misalign  (misalign),
    .epc       (epc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then wait for the next sampling point
  task automatic applyStimulus(input bit st, input bit ex, input bit er,
                               input bit jl, input logic [31:0] jlT,
                               input bit bt, input logic [31:0] btT,
                               input bit jm, input logic [31:0] jmT);
    stall = st; exc_req = ex; eret = er;
    jalr_take = jl; jalr_tgt = jlT;
    br_take = bt; br_tgt = btT;
    jmp_take = jm; jmp_tgt = jmT;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, '0);
  endtask

  function automatic logic [31:0] randTgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic modelTrap(input bit mis);
`ifdef PC_SEQ_EPC_EN
    eEpc = ePc;
`endif
    ePc = EXC_VEC; eSel = 3'd4; eAck = 1'b1; eRed = 1'b1; eMis = mis;
    eFv = 1'b0; mTrap = 1'b1; mPendRank = 0;
  endtask

  // Behavioural model: ranks 1..4 are jmp, branch, jalr, eret; the select
  // reported for rank r is 4-r, and rank 0 means sequential fetch.
  always @(posedge clk) begin
    eRed = 1'b0; eAck = 1'b0; eMis = 1'b0;
    if (rst) begin
      ePc = RESET_VEC; eSel = 3'd0; eFv = 1'b0; eEpc = '0;
      mPendRank = 0; mPendTgt = '0; mBoot = 1'b1; mTrap = 1'b0;
    end else if (mBoot) begin
      mBoot = 1'b0; eFv = 1'b1;
    end else if (mTrap) begin
      mTrap = 1'b0; eFv = 1'b1; ePc = ePc + 32'd4; eSel = 3'd0;
    end else begin
      mTk[0] = jmp_take;  mTg[0] = jmp_tgt;
      mTk[1] = br_take;   mTg[1] = br_tgt;
      mTk[2] = jalr_take; mTg[2] = jalr_tgt;
`ifdef PC_SEQ_EPC_EN
      mTk[3] = eret;
`else
      mTk[3] = 1'b0;
`endif
      mTg[3] = eEpc + 32'd4;
      mBestRank = 0; mBestTgt = '0;
      for (int k = 0; k < 4; k++) begin
        if (mTk[k]) begin
          mBestRank = k + 1; mBestTgt = mTg[k];
        end
      end
      if (exc_req) begin
        modelTrap(1'b0);
      end else if (stall) begin
        if (mBestRank > mPendRank) begin
          mPendRank = mBestRank; mPendTgt = mBestTgt;
        end
      end else begin
        if (mPendRank > 0 && mPendRank >= mBestRank) begin
          mBestRank = mPendRank; mBestTgt = mPendTgt;
        end
        mPendRank = 0;
        if (mBestRank == 0) begin
          ePc = ePc + 32'd4; eSel = 3'd0;
        end else if (mBestTgt[1:0] != 2'b00) begin
          modelTrap(1'b1);
        end else begin
          ePc = mBestTgt; eSel = 3'(4 - mBestRank); eRed = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cyc_pc", pc, ePc);
      checkOutput("cyc_sel", 32'(sel), 32'(eSel));
      checkOutput("cyc_fetch_vld", 32'(fetch_vld), 32'(eFv));
      checkOutput("cyc_redirect", 32'(redirect), 32'(eRed));
      checkOutput("cyc_exc_ack", 32'(exc_ack), 32'(eAck));
      checkOutput("cyc_misalign", 32'(misalign), 32'(eMis));
      checkOutput("cyc_epc", epc, eEpc);
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    idle();
    cmpEn = 1'b1;
    checkOutput("rst_pc", pc, 32'h00001000);
    checkOutput("rst_fetch_vld", 32'(fetch_vld), 32'd0);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_epc", epc, 32'd0);
    rst = 1'b0;

    // Boot, then sequential fetch
    idle();
    checkOutput("boot_pc", pc, 32'h00001000);
    checkOutput("boot_fetch_vld", 32'(fetch_vld), 32'd1);
    idle();
    checkOutput("seq_pc1", pc, 32'h00001004);
    repeat (5) idle();
    checkOutput("seq_pc6", pc, 32'h00001018);

    // Misaligned jalr beats aligned branch and becomes an exception
    applyStimulus(0, 0, 0, 1, 32'h00007612, 1, 32'h00008870, 0, '0);
    checkOutput("mis_pc", pc, 32'h00000080);
    checkOutput("mis_sel", 32'(sel), 32'd4);
    checkOutput("mis_flag", 32'(misalign), 32'd1);
    checkOutput("mis_ack", 32'(exc_ack), 32'd1);
    checkOutput("trap_fetch_vld", 32'(fetch_vld), 32'd0);
    idle();
    checkOutput("trap_exit_pc", pc, 32'h00000084);

    // Aligned jalr beats branch
    applyStimulus(0, 0, 0, 1, 32'h00007610, 1, 32'h00008870, 0, '0);
    checkOutput("jalr_pc", pc, 32'h00007610);
    checkOutput("jalr_sel", 32'(sel), 32'd1);
    checkOutput("jalr_redirect", 32'(redirect), 32'd1);

    // Stall buffering: branch replaces the buffered jump
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 1, 32'h00204034);
    checkOutput("hold_pc1", pc, 32'h00007610);
    applyStimulus(1, 0, 0, 0, '0, 1, 32'h00000044, 0, '0);
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 0, '0);
    checkOutput("hold_pc3", pc, 32'h00007610);
    idle();
    checkOutput("release_pc", pc, 32'h00000044);
    checkOutput("release_sel", 32'(sel), 32'd2);

    // Exception beats stall
    applyStimulus(1, 1, 0, 0, '0, 0, '0, 0, '0);
    checkOutput("excstall_pc", pc, 32'h00000080);
    checkOutput("excstall_fv", 32'(fetch_vld), 32'd0);
    idle();
    checkOutput("excstall_next", pc, 32'h00000084);

    // Wrap-around of the sequential path
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 1, 32'hFFFFFFFC);
    checkOutput("wrap_top", pc, 32'hFFFFFFFC);
    idle();
    checkOutput("wrap_pc", pc, 32'h00000000);
    checkOutput("wrap_redirect", 32'(redirect), 32'd0);

    // Exception save and return
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 1, 32'h00001010);
    applyStimulus(0, 1, 0, 0, '0, 0, '0, 0, '0);
`ifdef PC_SEQ_EPC_EN
    checkOutput("epc_saved", epc, 32'h00001010);
`else
    checkOutput("epc_zero", epc, 32'h00000000);
`endif
    idle();
    applyStimulus(0, 0, 1, 0, '0, 0, '0, 0, '0);
`ifdef PC_SEQ_EPC_EN
    checkOutput("eret_pc", pc, 32'h00001014);
    checkOutput("eret_redirect", 32'(redirect), 32'd1);
`else
    checkOutput("eret_pc", pc, 32'h00000088);
    checkOutput("eret_redirect", 32'(redirect), 32'd0);
`endif

    // Reset in the middle of a stall clears the buffered redirect
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 1, 32'h00002000);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 0, '0);
    checkOutput("rststall_pc", pc, 32'h00001000);
    checkOutput("rststall_fv", 32'(fetch_vld), 32'd0);
    rst = 1'b0;
    idle();
    idle();
    checkOutput("rststall_seq", pc, 32'h00001004);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rT0 = randTgt(); rT1 = randTgt(); rT2 = randTgt();
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 31) == 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 7) == 0, rT0,
                    $urandom_range(0, 5) == 0, rT1,
                    $urandom_range(0, 7) == 0, rT2);
    end
    rst = 1'b0;
    idle();

    cmpEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
